// File: rtl/pcs_mon_pkg.sv
// Shared types, K28.5 codewords and helpers for the PCS TX link monitor.
package pcs_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        TRACK
    } mon_state_e;

    localparam logic [9:0] K28_5_RDN     = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP     = 10'b1100000101;
    localparam int         RESYNC_THRESH = 8;

    function automatic logic [3:0] popcount10(input logic [9:0] sym);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, sym[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pcs_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
module pcs_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pcs_tx_link_monitor.sv
// Watches the PCS TX path: enable->enable_PMA latency, 8b/10b running disparity after comma lock.
// Optional data-hold check on enable deassertion is built when PCS_MON_HOLD_CHECK_EN is defined.
module pcs_tx_link_monitor
    import pcs_mon_pkg::*;
#(
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 8,
    parameter int LOCK_COMMAS = 2
) (
    input  logic             Bit_Rate_10,
    input  logic             Rst,
    input  logic             enable,
    input  logic             enable_PMA,
    input  logic [9:0]       data_out,
    input  logic             clr_cnt,
    output logic             en_err,
    output logic             disp_err,
    output logic             locked,
    output logic             rd_pos,
    output logic [CNT_W-1:0] en_err_cnt,
    output logic [CNT_W-1:0] disp_err_cnt,
    output logic             err_sticky
`ifdef PCS_MON_HOLD_CHECK_EN
    ,
    output logic             hold_err
`endif
);

    localparam int FILL_W = $clog2(LATENCY + 1);

    logic [LATENCY-1:0] en_pipe;
    logic [LATENCY-1:0] en_pipe_next;
    logic [FILL_W-1:0]  fill;
    logic               en_mismatch;

    generate
        if (LATENCY == 1) begin : g_pipe_single
            assign en_pipe_next = enable;
        end else begin : g_pipe_multi
            assign en_pipe_next = {en_pipe[LATENCY-2:0], enable};
        end
    endgenerate

    // No compare until the pipeline holds LATENCY real samples of enable.
    assign en_mismatch = (fill == FILL_W'(LATENCY)) && (en_pipe[LATENCY-1] != enable_PMA);

    always_ff @(posedge Bit_Rate_10) begin
        if (Rst) begin
            en_pipe <= '0;
            fill    <= '0;
            en_err  <= 1'b0;
        end else begin
            en_pipe <= en_pipe_next;
            if (fill != FILL_W'(LATENCY)) begin
                fill <= fill + FILL_W'(1);
            end
            en_err <= en_mismatch;
        end
    end

    mon_state_e state, state_next;
    logic [3:0] comma_cnt, comma_cnt_next;
    logic [3:0] err_run, err_run_next;
    logic       rd_next;
    logic       disp_flag;
    logic       sym_ok;
    logic [3:0] weight;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        comma_cnt_next = comma_cnt;
        err_run_next   = err_run;
        rd_next        = rd_pos;
        disp_flag      = 1'b0;
        sym_ok         = 1'b1;
        weight         = popcount10(data_out);
        if (enable_PMA) begin
            case (state)
                IDLE: state_next = HUNT;
                HUNT: begin
                    if ((data_out == K28_5_RDN) || (data_out == K28_5_RDP)) begin
                        if (comma_cnt == 4'(LOCK_COMMAS - 1)) begin
                            state_next     = TRACK;
                            comma_cnt_next = '0;
                            err_run_next   = '0;
                            rd_next        = (data_out == K28_5_RDN);
                        end else begin
                            comma_cnt_next = comma_cnt + 4'd1;
                        end
                    end else begin
                        comma_cnt_next = '0;
                    end
                end
                TRACK: begin
                    // A 6/4 symbol always forces RD to the polarity it implies, legal or not.
                    case (weight)
                        4'd5: sym_ok = 1'b1;
                        4'd6: begin
                            sym_ok  = !rd_pos;
                            rd_next = 1'b1;
                        end
                        4'd4: begin
                            sym_ok  = rd_pos;
                            rd_next = 1'b0;
                        end
                        default: sym_ok = 1'b0;
                    endcase
                    if (!sym_ok) begin
                        disp_flag = 1'b1;
                        if (err_run == 4'(RESYNC_THRESH - 1)) begin
                            state_next     = HUNT;
                            err_run_next   = '0;
                            comma_cnt_next = '0;
                        end else begin
                            err_run_next = err_run + 4'd1;
                        end
                    end else begin
                        err_run_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Bit_Rate_10) begin
        if (Rst) begin
            state     <= IDLE;
            comma_cnt <= '0;
            err_run   <= '0;
            rd_pos    <= 1'b0;
            disp_err  <= 1'b0;
        end else begin
            state     <= state_next;
            comma_cnt <= comma_cnt_next;
            err_run   <= err_run_next;
            rd_pos    <= rd_next;
            disp_err  <= disp_flag;
        end
    end

    assign locked = (state == TRACK);

    logic disp_inc;

`ifdef PCS_MON_HOLD_CHECK_EN
    logic       prev_pma;
    logic [9:0] prev_data;
    logic       hold_flag;

    assign hold_flag = !enable && prev_pma && (data_out != prev_data);
    assign disp_inc  = disp_flag | hold_flag;

    always_ff @(posedge Bit_Rate_10) begin
        if (Rst) begin
            prev_pma  <= 1'b0;
            prev_data <= '0;
            hold_err  <= 1'b0;
        end else begin
            prev_pma  <= enable_PMA;
            prev_data <= data_out;
            hold_err  <= hold_flag;
        end
    end
`else
    assign disp_inc = disp_flag;
`endif

    always_ff @(posedge Bit_Rate_10) begin
        if (Rst || clr_cnt) begin
            err_sticky <= 1'b0;
        end else if (en_mismatch || disp_inc) begin
            err_sticky <= 1'b1;
        end
    end

    pcs_sat_counter #(.CNT_W(CNT_W)) u_en_cnt (
        .clk (Bit_Rate_10),
        .rst (Rst),
        .inc (en_mismatch),
        .clr (clr_cnt),
        .cnt (en_err_cnt)
    );

    pcs_sat_counter #(.CNT_W(CNT_W)) u_disp_cnt (
        .clk (Bit_Rate_10),
        .rst (Rst),
        .inc (disp_inc),
        .clr (clr_cnt),
        .cnt (disp_err_cnt)
    );

endmodule

// File: tb/tb_pcs_tx_link_monitor.sv
// Scoreboard bench for pcs_tx_link_monitor: directed scenarios plus randomized traffic vs a behavioural model.
module tb_pcs_tx_link_monitor;

    localparam int LAT   = 3;
    localparam int CW    = 8;
    localparam int LOCKN = 2;
    localparam int SAT   = (1 << CW) - 1;

    localparam logic [9:0] CM    = 10'b0011111010;
    localparam logic [9:0] CP    = 10'b1100000101;
    localparam logic [9:0] D21_5 = 10'b1010101010;
    localparam logic [9:0] ONES  = 10'b1111111111;
    localparam logic [9:0] SYM_W4 = 10'b0101010100;
    localparam logic [9:0] SYM_W6 = 10'b1010101011;

    logic          Bit_Rate_10 = 1'b0;
    logic          Rst = 1'b1;
    logic          enable = 1'b0;
    logic          enable_PMA = 1'b0;
    logic [9:0]    data_out = '0;
    logic          clr_cnt = 1'b0;
    logic          en_err, disp_err, locked, rd_pos, err_sticky;
    logic [CW-1:0] en_err_cnt, disp_err_cnt;
`ifdef PCS_MON_HOLD_CHECK_EN
    logic          hold_err;
`endif

    pcs_tx_link_monitor #(.LATENCY(LAT), .CNT_W(CW), .LOCK_COMMAS(LOCKN)) dut (
        .Bit_Rate_10  (Bit_Rate_10),
        .Rst          (Rst),
        .enable       (enable),
        .enable_PMA   (enable_PMA),
        .data_out     (data_out),
        .clr_cnt      (clr_cnt),
        .en_err       (en_err),
        .disp_err     (disp_err),
        .locked       (locked),
        .rd_pos       (rd_pos),
        .en_err_cnt   (en_err_cnt),
        .disp_err_cnt (disp_err_cnt),
        .err_sticky   (err_sticky)
`ifdef PCS_MON_HOLD_CHECK_EN
        ,
        .hold_err     (hold_err)
`endif
    );

    always #5 Bit_Rate_10 = ~Bit_Rate_10;

    typedef struct packed {
        logic          en_err;
        logic          disp_err;
        logic          hold_err;
        logic          locked;
        logic          rd_pos;
        logic [CW-1:0] en_cnt;
        logic [CW-1:0] disp_cnt;
        logic          sticky;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Behavioural reference: mode 0 = waiting for traffic, 1 = hunting commas, 2 = tracking RD.
    bit         ehist[$];
    int         mode, commas, errs, m_en_cnt, m_disp_cnt;
    bit         m_rd, m_sticky, m_prev_pma;
    logic [9:0] m_prev_data;

    task automatic model_step();
        obs_t o;
        bit   e_err, d_err, h_err, legal;
        int   w;
        e_err = 0; d_err = 0; h_err = 0;
        if (Rst) begin
            ehist.delete();
            mode = 0; commas = 0; errs = 0; m_rd = 0;
            m_en_cnt = 0; m_disp_cnt = 0; m_sticky = 0;
            m_prev_pma = 0; m_prev_data = '0;
        end else begin
            if (ehist.size() == LAT) e_err = (ehist[0] != enable_PMA);
            ehist.push_back(enable);
            if (ehist.size() > LAT) void'(ehist.pop_front());
            if (enable_PMA) begin
                if (mode == 0) begin
                    mode = 1;
                end else if (mode == 1) begin
                    if (data_out == CM || data_out == CP) begin
                        commas++;
                        if (commas == LOCKN) begin
                            mode = 2; m_rd = (data_out == CM); commas = 0; errs = 0;
                        end
                    end else begin
                        commas = 0;
                    end
                end else begin
                    w = $countones(data_out);
                    legal = (w == 5) || (w == 6 && !m_rd) || (w == 4 && m_rd);
                    if (w == 6) m_rd = 1;
                    else if (w == 4) m_rd = 0;
                    if (!legal) begin
                        d_err = 1;
                        errs++;
                        if (errs == 8) begin
                            mode = 1; errs = 0; commas = 0;
                        end
                    end else begin
                        errs = 0;
                    end
                end
            end
`ifdef PCS_MON_HOLD_CHECK_EN
            h_err = !enable && m_prev_pma && (data_out !== m_prev_data);
`endif
            m_prev_pma  = enable_PMA;
            m_prev_data = data_out;
            if (clr_cnt) begin
                m_en_cnt = 0; m_disp_cnt = 0; m_sticky = 0;
            end else begin
                if (e_err && m_en_cnt < SAT) m_en_cnt++;
                if ((d_err || h_err) && m_disp_cnt < SAT) m_disp_cnt++;
                if (e_err || d_err || h_err) m_sticky = 1;
            end
        end
        o.en_err   = e_err;
        o.disp_err = d_err;
        o.hold_err = h_err;
        o.locked   = (mode == 2);
        o.rd_pos   = m_rd;
        o.en_cnt   = CW'(m_en_cnt);
        o.disp_cnt = CW'(m_disp_cnt);
        o.sticky   = m_sticky;
        exp_q.push_back(o);
    endtask

    function automatic obs_t sample_dut();
        obs_t a;
        a.en_err   = en_err;
        a.disp_err = disp_err;
`ifdef PCS_MON_HOLD_CHECK_EN
        a.hold_err = hold_err;
`else
        a.hold_err = 1'b0;
`endif
        a.locked   = locked;
        a.rd_pos   = rd_pos;
        a.en_cnt   = en_err_cnt;
        a.disp_cnt = disp_err_cnt;
        a.sticky   = err_sticky;
        return a;
    endfunction

    // Monitor: one expected observation per clock edge, compared mid-cycle.
    initial begin
        int   cyc = 0;
        obs_t e;
        forever begin
            @(negedge Bit_Rate_10);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cyc%0d", cyc), 64'(sample_dut()), 64'(e));
                cyc++;
            end
        end
    end

    task automatic drive(input bit r, input bit e, input bit p, input logic [9:0] d, input bit c);
        Rst = r; enable = e; enable_PMA = p; data_out = d; clr_cnt = c;
        @(posedge Bit_Rate_10);
        model_step();
        #1;
    endtask

    task automatic lock_rdn();
        drive(0, 1, 1, CM, 0);
        drive(0, 1, 1, CM, 0);
    endtask

    initial begin
        bit         e_r, p_r;
        bit         sh[$];
        logic [9:0] d_r;

        drive(1, 0, 0, '0, 0);
        drive(1, 0, 0, '0, 0);
        check("rst_locked", locked, 0);
        check("rst_cnts", {en_err_cnt, disp_err_cnt, err_sticky, rd_pos}, 0);

        // enable_PMA follows enable by exactly LAT cycles: no latency error.
        for (int i = 0; i < 10; i++) drive(0, 1, (i >= LAT), D21_5, 0);
        check("lat_ok_cnt", en_err_cnt, 0);
        check("lat_ok_sticky", err_sticky, 0);

        // enable_PMA arrives one cycle early: error at rise and at fall of the window.
        for (int i = 0; i < 20; i++) drive(0, (i >= 5 && i < 10), (i < 3) || (i >= 7 && i < 12), D21_5, 0);
        check("lat_err_cnt", en_err_cnt, 2);
        check("lat_err_sticky", err_sticky, 1);
        drive(0, 0, 0, D21_5, 1);
        check("clr_en_cnt", en_err_cnt, 0);
        check("clr_sticky", err_sticky, 0);

        for (int i = 0; i < LAT; i++) drive(0, 1, 0, D21_5, 0);
        lock_rdn();
        check("lock_locked", locked, 1);
        check("lock_rd", rd_pos, 1);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, D21_5, 0);
        check("d21_disp_cnt", disp_err_cnt, 0);
        check("d21_rd", rd_pos, 1);

        // w=6 symbol while RD is positive.
        drive(0, 1, 1, CM, 0);
        check("w6_pulse", disp_err, 1);
        check("w6_rd", rd_pos, 1);
        check("w6_cnt", disp_err_cnt, 1);
        drive(0, 1, 1, D21_5, 0);
        check("w6_pulse_end", disp_err, 0);
        drive(0, 1, 1, D21_5, 1);

        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 1, ONES, 0);
            if (i == 6) check("ones_still_locked", locked, 1);
            if (i == 7) check("ones_unlock", locked, 0);
        end
        check("ones_cnt", disp_err_cnt, 8);

        for (int r = 0; r < 33; r++) begin
            lock_rdn();
            for (int i = 0; i < 8; i++) drive(0, 1, 1, ONES, 0);
        end
        check("sat_cnt", disp_err_cnt, SAT);
        lock_rdn();
        for (int i = 0; i < 8; i++) drive(0, 1, 1, ONES, 0);
        check("sat_hold", disp_err_cnt, SAT);

        drive(0, 1, 1, 10'h17C, 0);
        drive(0, 0, 1, 10'h283, 0);
`ifdef PCS_MON_HOLD_CHECK_EN
        check("hold_pulse", hold_err, 1);
`endif
        drive(0, 0, 1, 10'h283, 0);
`ifdef PCS_MON_HOLD_CHECK_EN
        check("hold_quiet", hold_err, 0);
`endif
        drive(0, 0, 1, 10'h283, 1);
        check("clr2_cnts", {en_err_cnt, disp_err_cnt}, 0);
        check("clr2_sticky", err_sticky, 0);

        // Randomized traffic: mostly well-timed enable_PMA, commas-heavy symbol mix.
        drive(1, 0, 0, '0, 0);
        e_r = 0;
        d_r = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) e_r = !e_r;
            p_r = (sh.size() >= LAT) ? sh[sh.size() - LAT] : 1'b0;
            if ($urandom_range(0, 39) == 0) p_r = !p_r;
            sh.push_back(e_r);
            if (sh.size() > LAT) void'(sh.pop_front());
            case ($urandom_range(0, 7))
                0, 1: d_r = CM;
                2:    d_r = CP;
                3:    d_r = D21_5;
                4:    d_r = SYM_W4;
                5:    d_r = SYM_W6;
                6:    d_r = 10'($urandom);
                default: d_r = d_r;
            endcase
            if ($urandom_range(0, 399) == 0) begin
                drive(1, e_r, p_r, d_r, 0);
                sh.delete();
            end else begin
                drive(0, e_r, p_r, d_r, ($urandom_range(0, 49) == 0));
            end
        end

        drive(1, 1, 1, D21_5, 0);
        check("midrst_state", {locked, rd_pos, err_sticky}, 0);
        check("midrst_cnts", {en_err_cnt, disp_err_cnt}, 0);

        repeat (3) @(negedge Bit_Rate_10);
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
